// File: rtl/tp84_pll_retune_pkg.sv
// Shared types and constants for the TP84 PLL retune sequencer.
package tp84_pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MODE,
    ST_W_FRAC,
    ST_W_START,
    ST_GAP,
    ST_WAIT_DROP,
    ST_WAIT_LOCK,
    ST_SETTLE
  } pll_state_e;

  localparam logic [5:0]  ADDR_MODE       = 6'd0;
  localparam logic [5:0]  ADDR_START      = 6'd2;
  localparam logic [5:0]  ADDR_FRAC       = 6'd7;

  localparam logic [31:0] FRAC_NATIVE_DEF = 32'd3639383488;
  localparam logic [31:0] FRAC_UNDER_DEF  = 32'd3268298314;

  function automatic logic [31:0] frac_word(input logic        under,
                                            input logic [31:0] native,
                                            input logic [31:0] underclk);
    return under ? underclk : native;
  endfunction

endpackage

// File: rtl/tp84_pll_retune_if.sv
// Avalon-MM management port towards the pll_cfg reconfiguration controller.
interface tp84_pll_retune_if;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (output mgmt_write, mgmt_address, mgmt_writedata,
                  input  mgmt_waitrequest);
  modport slave  (input  mgmt_write, mgmt_address, mgmt_writedata,
                  output mgmt_waitrequest);
endinterface

// File: rtl/tp84_pll_retune_sync_stable.sv
// Two-flop synchronizer with an optional third flop flagging a settled value.
module sync_stable #(
  parameter bit STABLE_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic stable
);

  logic s1, s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  generate
    if (STABLE_EN) begin : g_stable
      logic prev;
      always_ff @(posedge clk) begin
        if (!reset) prev <= 1'b0;
        else        prev <= s2;
      end
      assign stable = (s2 == prev);
    end else begin : g_nostable
      assign stable = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/tp84_pll_retune.sv
// Retunes the core PLL between native and underclock fractions via pll_cfg,
// holding the core until the PLL has relocked and settled.
module tp84_pll_retune
  import tp84_pll_pkg::*;
#(
  parameter logic [31:0] FRAC_NATIVE   = FRAC_NATIVE_DEF,
  parameter logic [31:0] FRAC_UNDER    = FRAC_UNDER_DEF,
  parameter int unsigned WRITE_GAP     = 3,
  parameter int unsigned DROP_TIMEOUT  = 1024,
  parameter int unsigned SETTLE_CYCLES = 4096
) (
  input  logic                      clk_50m,
  input  logic                      reset,
  input  logic                      underclock_req,
  input  logic                      pll_locked,
  tp84_pll_retune_if.master         mgmt,
  output logic                      busy,
  output logic                      core_hold,
  output logic                      underclock_applied
);

  localparam int unsigned GAP_W    = (WRITE_GAP > 1)     ? $clog2(WRITE_GAP)     : 1;
  localparam int unsigned DROP_W   = (DROP_TIMEOUT > 1)  ? $clog2(DROP_TIMEOUT)  : 1;
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(WRITE_GAP - 1);
  localparam logic [DROP_W-1:0]   DROP_LAST   = DROP_W'(DROP_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic req_s, req_stable, lock_s, lock_stable_unused;

  sync_stable #(.STABLE_EN(1'b1)) u_req_sync (
    .clk    (clk_50m),
    .reset  (reset),
    .d      (underclock_req),
    .q      (req_s),
    .stable (req_stable)
  );

  sync_stable #(.STABLE_EN(1'b0)) u_lock_sync (
    .clk    (clk_50m),
    .reset  (reset),
    .d      (pll_locked),
    .q      (lock_s),
    .stable (lock_stable_unused)
  );

  pll_state_e           state, after_gap;
  logic                 target, dirty;
  logic [GAP_W-1:0]     gap_cnt;
  logic [DROP_W-1:0]    drop_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;

  // One shared GAP state; after_gap remembers which step follows it.
  always_ff @(posedge clk_50m) begin
    if (!reset) begin
      state               <= ST_IDLE;
      after_gap           <= ST_W_FRAC;
      target              <= 1'b0;
      dirty               <= 1'b1;
      underclock_applied  <= 1'b0;
      busy                <= 1'b0;
      core_hold           <= 1'b0;
      mgmt.mgmt_write     <= 1'b0;
      mgmt.mgmt_address   <= '0;
      mgmt.mgmt_writedata <= '0;
      gap_cnt             <= '0;
      drop_cnt            <= '0;
      settle_cnt          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_stable && ((req_s != underclock_applied) || dirty)) begin
            target              <= req_s;
            state               <= ST_W_MODE;
            busy                <= 1'b1;
            core_hold           <= 1'b1;
            mgmt.mgmt_write     <= 1'b1;
            mgmt.mgmt_address   <= ADDR_MODE;
            mgmt.mgmt_writedata <= '0;
          end
        end
        ST_W_MODE, ST_W_FRAC, ST_W_START: begin
          if (!mgmt.mgmt_waitrequest) begin
            mgmt.mgmt_write <= 1'b0;
            gap_cnt         <= '0;
            state           <= ST_GAP;
            after_gap       <= (state == ST_W_MODE) ? ST_W_FRAC :
                               (state == ST_W_FRAC) ? ST_W_START : ST_WAIT_DROP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= after_gap;
            case (after_gap)
              ST_W_FRAC: begin
                mgmt.mgmt_write     <= 1'b1;
                mgmt.mgmt_address   <= ADDR_FRAC;
                mgmt.mgmt_writedata <= frac_word(target, FRAC_NATIVE, FRAC_UNDER);
              end
              ST_W_START: begin
                mgmt.mgmt_write     <= 1'b1;
                mgmt.mgmt_address   <= ADDR_START;
                mgmt.mgmt_writedata <= '0;
              end
              default: drop_cnt <= '0;
            endcase
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_WAIT_DROP: begin
          if (!lock_s || (drop_cnt == DROP_LAST)) state <= ST_WAIT_LOCK;
          else                                     drop_cnt <= drop_cnt + 1'b1;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state              <= ST_IDLE;
            underclock_applied <= target;
            dirty              <= 1'b0;
            busy               <= 1'b0;
            core_hold          <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tp84_pll_retune.sv
// Scoreboard bench for tp84_pll_retune: expected writes/applied modes queued by
// stimulus, popped by a monitor on each accepted write and each sequence end.
module tb_tp84_pll_retune;
  import tp84_pll_pkg::*;

  localparam logic [31:0] NAT = 32'd3639383488;
  localparam logic [31:0] UND = 32'd3268298314;

  logic clk_50m = 1'b0;
  logic reset = 1'b0;
  logic underclock_req = 1'b0;
  logic pll_locked = 1'b1;
  logic busy, core_hold, underclock_applied;

  tp84_pll_retune_if mgmt();

  tp84_pll_retune #(
    .FRAC_NATIVE   (NAT),
    .FRAC_UNDER    (UND),
    .WRITE_GAP     (3),
    .DROP_TIMEOUT  (1024),
    .SETTLE_CYCLES (4096)
  ) dut (
    .clk_50m            (clk_50m),
    .reset              (reset),
    .underclock_req     (underclock_req),
    .pll_locked         (pll_locked),
    .mgmt               (mgmt),
    .busy               (busy),
    .core_hold          (core_hold),
    .underclock_applied (underclock_applied)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          gap;
  } wr_t;

  wr_t  exp_wr[$];
  logic exp_app[$];
  wr_t  e_wr;
  logic e_app;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   last_start = 0;
  int   hold_fall = 0;
  logic prev_hold = 1'b0;
  bit   auto_lock = 1'b1;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic tgt, input int frac_gap);
    exp_wr.push_back('{ADDR_MODE, 32'd0, 0});
    exp_wr.push_back('{ADDR_FRAC, tgt ? UND : NAT, frac_gap});
    exp_wr.push_back('{ADDR_START, 32'd0, 4});
    exp_app.push_back(tgt);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while ((exp_app.size() != 0 || busy !== 1'b0) && n < limit) begin
      @(negedge clk_50m);
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $display("FAIL %s: sequence not finished after %0d cycles, required completion", name, n);
    end
  endtask

  task automatic wait_write(input string name, input logic [5:0] addr, input int limit);
    int n = 0;
    while (!(mgmt.mgmt_write === 1'b1 && mgmt.mgmt_address === addr) && n < limit) begin
      @(negedge clk_50m);
      n++;
    end
    chk(name, {mgmt.mgmt_write, mgmt.mgmt_address}, {1'b1, addr});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write"}, mgmt.mgmt_write, 0);
    chk({tag, "_addr"}, mgmt.mgmt_address, 0);
    chk({tag, "_data"}, mgmt.mgmt_writedata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hold"}, core_hold, 0);
    chk({tag, "_applied"}, underclock_applied, 0);
  endtask

  // Monitor: compares every accepted write and the mode reported at each sequence end.
  initial forever begin
    @(negedge clk_50m);
    #1;
    if (reset === 1'b1 && mgmt.mgmt_write === 1'b1 && mgmt.mgmt_waitrequest === 1'b0) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: addr=%0d data=%0d, required no write", mgmt.mgmt_address, mgmt.mgmt_writedata);
      end else begin
        e_wr = exp_wr.pop_front();
        if (mgmt.mgmt_address !== e_wr.addr || mgmt.mgmt_writedata !== e_wr.data) begin
          bad++;
          $display("FAIL write_content: addr=%0d data=%0d, required addr=%0d data=%0d",
                   mgmt.mgmt_address, mgmt.mgmt_writedata, e_wr.addr, e_wr.data);
        end
        if (e_wr.gap != 0) begin
          total++;
          if (cyc - last_acc != e_wr.gap) begin
            bad++;
            $display("FAIL write_spacing: addr=%0d spacing=%0d, required %0d", e_wr.addr, cyc - last_acc, e_wr.gap);
          end
        end
      end
      last_acc = cyc;
      if (mgmt.mgmt_address === ADDR_START) last_start = cyc;
    end
    if (reset === 1'b1 && prev_hold === 1'b1 && core_hold === 1'b0) begin
      hold_fall = cyc;
      total++;
      if (exp_app.size() == 0) begin
        bad++;
        $display("FAIL seq_end_unexpected: applied=%0d, required no sequence end", underclock_applied);
      end else begin
        e_app = exp_app.pop_front();
        if (underclock_applied !== e_app) begin
          bad++;
          $display("FAIL applied_mode: got %0d expected %0d", underclock_applied, e_app);
        end
      end
    end
    prev_hold = core_hold;
  end

  // PLL model: lock drops 20 cycles after START is accepted, returns 50 cycles later.
  initial forever begin
    @(negedge clk_50m);
    #1;
    if (auto_lock && reset === 1'b1 && mgmt.mgmt_write === 1'b1 &&
        mgmt.mgmt_waitrequest === 1'b0 && mgmt.mgmt_address === ADDR_START) begin
      repeat (20) @(negedge clk_50m);
      pll_locked = 1'b0;
      repeat (50) @(negedge clk_50m);
      pll_locked = 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int s, g, n;
    mgmt.mgmt_waitrequest = 1'b0;
    repeat (5) @(negedge clk_50m);
    chk_reset_outputs("reset_state");

    // Reset release with req=0: dirty forces a native programming pass.
    push_seq(1'b0, 4);
    reset = 1'b1;
    wait_write("first_write_after_reset", ADDR_MODE, 4);
    wait_idle("seq_native_boot", 6000);

    // Request edge latency and underclock programming.
    push_seq(1'b1, 4);
    underclock_req = 1'b1;
    repeat (3) @(negedge clk_50m);
    chk("req_latency_before", mgmt.mgmt_write, 0);
    @(negedge clk_50m);
    chk("req_latency_write", mgmt.mgmt_write, 1);
    chk("applied_held_during_seq", underclock_applied, 0);
    wait_idle("seq_under", 6000);

    // Stall the FRAC write for 10 cycles.
    exp_wr.push_back('{ADDR_MODE, 32'd0, 0});
    exp_wr.push_back('{ADDR_FRAC, NAT, 14});
    exp_wr.push_back('{ADDR_START, 32'd0, 4});
    exp_app.push_back(1'b0);
    underclock_req = 1'b0;
    wait_write("stall_mode_seen", ADDR_MODE, 10);
    @(negedge clk_50m);
    mgmt.mgmt_waitrequest = 1'b1;
    wait_write("stall_frac_seen", ADDR_FRAC, 10);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk_50m);
      chk("stall_hold", {mgmt.mgmt_write, mgmt.mgmt_address, mgmt.mgmt_writedata}, {1'b1, ADDR_FRAC, NAT});
    end
    @(negedge clk_50m);
    mgmt.mgmt_waitrequest = 1'b0;
    wait_idle("seq_stall", 6000);

    // Lock never drops: WAIT_DROP times out after 1024 cycles.
    auto_lock = 1'b0;
    push_seq(1'b1, 4);
    underclock_req = 1'b1;
    wait_idle("seq_drop_timeout", 7000);
    chk("drop_timeout_span", hold_fall - last_start, 3 + 1024 + 1 + 4096 + 1);

    // One-cycle lock glitch during SETTLE restarts the settle count.
    push_seq(1'b0, 4);
    underclock_req = 1'b0;
    n = 0;
    while (!(mgmt.mgmt_write === 1'b1 && mgmt.mgmt_address === ADDR_START &&
             mgmt.mgmt_waitrequest === 1'b0) && n < 30) begin
      @(negedge clk_50m);
      n++;
    end
    s = cyc;
    repeat (1129) @(negedge clk_50m);
    pll_locked = 1'b0;
    g = cyc;
    @(negedge clk_50m);
    pll_locked = 1'b1;
    wait_idle("seq_settle_glitch", 7000);
    chk("settle_restart_span", hold_fall - g, 4099);
    chk("glitch_inside_settle", g - s, 1129);

    // Request flips back during WAIT_LOCK: finish, then a second pass.
    auto_lock = 1'b1;
    push_seq(1'b1, 4);
    push_seq(1'b0, 4);
    underclock_req = 1'b1;
    n = 0;
    while (pll_locked !== 1'b0 && n < 100) begin
      @(negedge clk_50m);
      n++;
    end
    repeat (10) @(negedge clk_50m);
    underclock_req = 1'b0;
    chk("flip_hold_active", core_hold, 1);
    wait_idle("seq_back_to_back", 14000);

    // Reset during a stalled write, with underclock applied beforehand.
    push_seq(1'b1, 4);
    underclock_req = 1'b1;
    wait_idle("seq_pre_reset", 6000);
    chk("applied_before_reset", underclock_applied, 1);
    mgmt.mgmt_waitrequest = 1'b1;
    underclock_req = 1'b0;
    wait_write("stalled_mode_seen", ADDR_MODE, 10);
    repeat (3) @(negedge clk_50m);
    reset = 1'b0;
    @(negedge clk_50m);
    chk_reset_outputs("mid_reset");
    repeat (3) @(negedge clk_50m);
    mgmt.mgmt_waitrequest = 1'b0;
    push_seq(1'b0, 0);
    reset = 1'b1;
    wait_write("first_write_after_mid_reset", ADDR_MODE, 4);
    wait_idle("seq_after_reset", 6000);

    chk("queues_drained", exp_wr.size() + exp_app.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tp84_pll_retune.md
# tp84_pll_retune

Management-side sequencer that retunes the Time Pilot '84 core PLL between native timing and the ~1% "60Hz Adjust" underclock. It sits directly upstream of the `pll_cfg` reconfiguration controller and drives its Avalon-MM management port. It watches the OSD underclock request, programs the fractional-K value and starts the reconfiguration. It then holds the core off until the PLL relocks, and reports which mode is actually applied so the core's sound-timing compensation follows the real clock.

## Interface
Parameters:
- `FRAC_NATIVE`, 32'd3639383488, K-counter fraction for native 49.152 MHz
- `FRAC_UNDER`, 32'd3268298314, K-counter fraction for underclock
- `WRITE_GAP`, 3, idle cycles after each accepted write
- `DROP_TIMEOUT`, 1024, max cycles to wait for `pll_locked` to fall after START
- `SETTLE_CYCLES`, 4096, cycles `pll_locked` must stay high before release

Ports:
- `clk_50m`  in  1  free-running management clock (not the retuned clock)
- `reset`  in  1  synchronous, active-low
- `underclock_req`  in  1  OSD request, asynchronous to `clk_50m`
- `pll_locked`  in  1  PLL lock, asynchronous
- `mgmt_waitrequest`  in  1  controller stall
- `mgmt_write`  out  1  write strobe
- `mgmt_address`  out  6  register address
- `mgmt_writedata`  out  32  register data
- `busy`  out  1  sequence in progress
- `core_hold`  out  1  request to pause/hold the core during retune
- `underclock_applied`  out  1  mode currently programmed into the PLL

## Operation
- `underclock_req` and `pll_locked` each pass through a 2-flop synchronizer. The request also has a third "previous" flop, and it counts as stable when sync == previous.
- `dirty` flag: set by reset. It forces one sequence with the current stable request, because the PLL state after a core reset is unknown.
- A sequence starts from IDLE when the request is stable and (request != `underclock_applied` or `dirty`). The target value is latched at that point.
- State sequence: IDLE -> W_MODE -> GAP -> W_FRAC -> GAP -> W_START -> GAP -> WAIT_DROP -> WAIT_LOCK -> SETTLE -> IDLE.
- W_MODE writes addr 0, data 0 (waitrequest mode).
- W_FRAC writes addr 7, data `FRAC_UNDER` if target else `FRAC_NATIVE`.
- W_START writes addr 2, data 0.
- Write rule: `mgmt_write`, address and data are asserted together and held stable until the first cycle with `mgmt_waitrequest`=0. `mgmt_write` deasserts on the next edge. The GAP counter then runs `WRITE_GAP` cycles.
- WAIT_DROP: exit on synced `pll_locked`=0, or after `DROP_TIMEOUT` cycles, whichever comes first.
- WAIT_LOCK: exit on synced `pll_locked`=1. There is no timeout; the block stays here until lock.
- SETTLE: count `SETTLE_CYCLES` consecutive locked cycles. Any loss of lock restarts the count from 0.
- On SETTLE exit: `underclock_applied` <= target, `dirty` <= 0, return to IDLE.
- A request change mid-sequence is ignored until IDLE, then re-evaluated. This can trigger an immediate back-to-back sequence.
- `busy` = state != IDLE. `core_hold` = state in {W_MODE..SETTLE}. Both are registered.

## Timing
- Reset values: `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0, `busy`=0, `core_hold`=0, `underclock_applied`=0, `dirty`=1, state IDLE.
- Request edge to `mgmt_write` high: third rising edge after the first edge that samples the new value, assuming `dirty`=0 and IDLE.
- After reset release, the first sequence starts ≤4 cycles later regardless of request value.
- Write accepted in the same cycle `mgmt_waitrequest` is low. Minimum write-to-write spacing is `WRITE_GAP`+1 cycles.
- Reset asserted mid-sequence: all outputs return to reset values on that edge, including `mgmt_write` dropping even if a write is pending. The sequence restarts from W_MODE after release.
- Counters are sized by `$clog2` of their parameter and saturate, never wrap.

## Structure
- Package `tp84_pll_pkg` holds the state enum, register address constants (MODE=0, START=2, FRAC=7) and the default fraction constants.
- One sub-module, `sync_stable`: a 2-flop synchronizer with an optional stability flop, instantiated for the request and for the lock signal.

## Test plan
- Reset release, req=0, waitrequest=0 -> writes (0,0), (7,3639383488), (2,0) spaced 4 cycles apart. Lock drop/rise -> `applied`=0, `core_hold` low after 4096 locked cycles.
- Toggle req 0->1 while idle -> `mgmt_write` on the 3rd edge, FRAC data 3268298314, `applied`=1 only after settle.
- Hold `mgmt_waitrequest`=1 for 10 cycles during W_FRAC -> addr/data/`mgmt_write` stable all 10 cycles, single acceptance.
- `pll_locked` never drops -> WAIT_DROP exits at exactly 1024 cycles. A lock glitch during SETTLE restarts the count.
- Flip req 1->0 during WAIT_LOCK -> current sequence completes with `applied`=1, then a second sequence programs `FRAC_NATIVE`.
- Assert reset during a stalled write -> `mgmt_write`=0 next edge. After release, full sequence reprograms the current req.
